// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO read path: output-buffer state encodings and depths.
// Pure definitions, no logic; imported by fifo_reader and skid_buffer2.
package fifo_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    localparam int unsigned BUF_DEPTH        = 2;
    localparam int unsigned FIFO_RD_LATENCY  = 1;
    localparam int unsigned FIFO_SYNC_STAGES = 2;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read-side and downstream valid/ready bundle for fifo_reader; pop_count exists only
// with FIFO_READER_STATS_EN. slave = fifo_reader view, master = FIFO/consumer view.
interface fifo_reader_if #(
    parameter int p_WIDTH = 8
`ifdef FIFO_READER_STATS_EN
    ,
    parameter int p_CNT_WIDTH = 32
`endif
);
    logic               fifo_empty;
    logic [p_WIDTH-1:0] fifo_rddata;
    logic               fifo_rdena;
    logic               m_valid;
    logic               m_ready;
    logic [p_WIDTH-1:0] m_data;
    logic [1:0]         level;
`ifdef FIFO_READER_STATS_EN
    logic [p_CNT_WIDTH-1:0] pop_count;

    modport slave (
        input  fifo_empty, fifo_rddata, m_ready,
        output fifo_rdena, m_valid, m_data, level, pop_count
    );
    modport master (
        output fifo_empty, fifo_rddata, m_ready,
        input  fifo_rdena, m_valid, m_data, level, pop_count
    );
`else
    modport slave (
        input  fifo_empty, fifo_rddata, m_ready,
        output fifo_rdena, m_valid, m_data, level
    );
    modport master (
        output fifo_empty, fifo_rddata, m_ready,
        input  fifo_rdena, m_valid, m_data, level
    );
`endif
endinterface

// File: rtl/skid_buffer2.sv
// Two-entry (head, skid) output buffer; load writes the word arriving this cycle, pop retires head.
// Registered outputs, zero-cycle pop; the caller must never load into a full buffer without a pop.
module skid_buffer2
    import fifo_pkg::*;
#(
    parameter int p_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [p_WIDTH-1:0] load_dat,
    input  logic               pop,
    output logic               head_vld,
    output logic [p_WIDTH-1:0] head_dat,
    output logic [1:0]         level
);

    buf_state_t         state_q, state_d;
    logic [p_WIDTH-1:0] head_q, head_d;
    logic [p_WIDTH-1:0] skid_q, skid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data entries carry no reset: they are only observed while state marks them occupied.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (load) begin
                    head_d  = load_dat;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (pop && load) begin
                    head_d = load_dat;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end else if (load) begin
                    skid_d  = load_dat;
                    state_d = BUF_TWO;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    head_d = skid_q;
                    if (load) begin
                        skid_d = load_dat;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    assign head_vld = (state_q != BUF_EMPTY);
    assign head_dat = head_q;
    assign level    = state_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == BUF_TWO && load && !pop));

endmodule

// File: rtl/fifo_reader.sv
// Drains a FIFO read port (1-cycle read latency) into a valid/ready stream; 2 cycles empty-to-valid, 1 word/cycle.
// Reads are throttled so buffered + in-flight words never exceed 2; FIFO_READER_STATS_EN adds pop_count.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int p_WIDTH     = 8,
    parameter int p_CNT_WIDTH = 32
) (
    input  logic          rdclk,
    input  logic          rdrst_n,
    fifo_reader_if.slave  bus
);

    if (p_WIDTH < 1 || p_CNT_WIDTH < 1) begin : g_bad_param
        $error("fifo_reader: widths must be >= 1");
    end

    logic               inflight_q, inflight_d;
    logic               pop;
    logic               rdena;
    logic [2:0]         occupancy;
    logic               head_vld;
    logic [p_WIDTH-1:0] head_dat;
    logic [1:0]         level;

    // Occupancy counts the word about to leave, so a full buffer can still refill in a draining cycle.
    always_comb begin
        pop        = head_vld & bus.m_ready;
        occupancy  = {1'b0, level} + {2'b00, inflight_q} - {2'b00, pop};
        rdena      = rdrst_n & ~bus.fifo_empty & (occupancy < 3'(BUF_DEPTH));
        inflight_d = rdena;
    end

    always_ff @(posedge rdclk) begin
        if (!rdrst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    skid_buffer2 #(
        .p_WIDTH (p_WIDTH)
    ) u_buf (
        .clk      (rdclk),
        .rst_n    (rdrst_n),
        .load     (inflight_q),
        .load_dat (bus.fifo_rddata),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .level    (level)
    );

    assign bus.fifo_rdena = rdena;
    assign bus.m_valid    = head_vld;
    assign bus.m_data     = head_dat;
    assign bus.level      = level;

`ifdef FIFO_READER_STATS_EN
    logic [p_CNT_WIDTH-1:0] pop_count_q, pop_count_d;

    always_comb begin
        pop_count_d = pop_count_q;
        if (pop) begin
            pop_count_d = pop_count_q + p_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge rdclk) begin
        if (!rdrst_n) begin
            pop_count_q <= '0;
        end else begin
            pop_count_q <= pop_count_d;
        end
    end

    assign bus.pop_count = pop_count_q;
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter: p_WIDTH, 8, data bus width in bits (>=1).
REQ-002 SHALL have parameter: p_CNT_WIDTH, 32, width of the optional pop counter (>=1).
REQ-003 SHALL have port: rdclk  input  1  read-domain clock; all state on posedge.
REQ-004 SHALL have port: rdrst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: fifo_empty  input  1  empty flag of the upstream FIFO read side.
REQ-006 SHALL have port: fifo_rddata  input  p_WIDTH  FIFO read data, valid exactly 1 cycle after an accepted fifo_rdena.
REQ-007 SHALL have port: fifo_rdena  output  1  FIFO read enable.
REQ-008 SHALL have port: m_valid  output  1  downstream word available.
REQ-009 SHALL have port: m_ready  input  1  downstream accepts word.
REQ-010 SHALL have port: m_data  output  p_WIDTH  downstream word.
REQ-011 SHALL have port: level  output  2  words held in the output buffer (0..2).
REQ-012 SHALL have port (FIFO_READER_STATS_EN only): pop_count  output  p_CNT_WIDTH  words delivered downstream.

Function
REQ-013 SHALL hold a 2-entry output buffer (head, skid) with states BUF_EMPTY, BUF_ONE, BUF_TWO; level SHALL equal 0/1/2 respectively.
REQ-014 SHALL track one in-flight bit, set in the cycle after fifo_rdena=1, cleared otherwise.
REQ-015 SHALL drive fifo_rdena = rdrst_n & ~fifo_empty & (level + inflight - pop < 2), where pop = m_valid & m_ready; the expression is combinational.
REQ-016 SHALL capture fifo_rddata into the buffer at the posedge where inflight=1; it SHALL never drop an in-flight word.
REQ-017 SHALL drive m_valid = (level != 0), m_data = head entry, both from registers.
REQ-018 SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-019 Transitions: EMPTY+arrive->ONE; ONE+pop->EMPTY; ONE+arrive->TWO; ONE+pop+arrive->ONE (head<=new); TWO+pop->ONE (head<=skid); TWO+pop+arrive->TWO (head<=skid, skid<=new). Other combinations hold state.
REQ-020 SHALL not arrive in BUF_TWO without pop, since REQ-015 forbids it; an assertion SHALL flag the violation.
REQ-021 SHALL sustain 1 word/cycle downstream when FIFO non-empty and m_ready=1 continuously.
REQ-022 Latency: first word SHALL appear on m_valid 2 cycles after fifo_empty falls with buffer empty (rdena cycle, capture, valid).
REQ-023 Word order SHALL equal FIFO order; no duplication, no loss.

Reset
REQ-024 With rdrst_n=0 at a posedge: state->BUF_EMPTY, inflight->0, level->0, m_valid->0, pop_count->0; m_data value is don't-care.
REQ-025 fifo_rdena SHALL be 0 in every cycle with rdrst_n=0.
REQ-026 Reset mid-operation SHALL discard buffered and in-flight words; the FIFO read side is reset together with this block by rdrst_n.

Configuration
REQ-027 Macro FIFO_READER_STATS_EN: when defined, pop_count SHALL exist and increment by 1 on each pop, wrapping modulo 2^p_CNT_WIDTH; when undefined, the port and counter SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-028 Buffer state encodings (BUF_EMPTY=0, BUF_ONE=1, BUF_TWO=2) SHALL reside in shared package fifo_pkg, with the async FIFO constants.
REQ-029 The 2-entry buffer SHALL be sub-module skid_buffer2 (load/pop/level interface); fifo_reader SHALL hold the rdena/inflight logic and the stats counter.

Verification
REQ-030 Reset: rdrst_n=0 for 3 cycles with fifo_empty=0 -> fifo_rdena=0, m_valid=0, level=0 throughout.
REQ-031 Single word: FIFO holds 0xA5, m_ready=1 -> rdena 1 cycle, m_valid=1 with m_data=0xA5 2 cycles after empty falls, then level=0.
REQ-032 Streaming: 16 words 0x00..0x0F, m_ready=1 -> 16 consecutive m_valid cycles, data in order, pop_count=16 (STATS_EN).
REQ-033 Backpressure: m_ready=0 with 5 words queued -> level reaches 2, fifo_rdena=0 thereafter, m_data holds 0x00; m_ready=1 -> words 0x00..0x04 in order, none lost.
REQ-034 Reset mid-stream: rdrst_n=0 while level=2 and inflight=1 -> next cycle level=0, m_valid=0, fifo_rdena=0.
REQ-035 Wrap: p_CNT_WIDTH=4, 17 pops -> pop_count=1.
